// File: rtl/vga_if.sv
// vga_if: VGA DAC output bundle carrying the pixel clock, syncs, blank and 8-bit R/G/B.
interface vga_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK;
  logic       VGA_SYNC;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: VGA timing generator streaming {R,G,B} from a show-ahead FIFO, frame-aligned start.
// Optional macro VGA_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow_cnt output.
module vga_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [23:0] rdata,
  input  logic        rempty,
  output logic        rinc,
`ifdef VGA_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  vga_if.master       vga_ifm
);

  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HTOT + 1);
  localparam int VW   = $clog2(VTOT + 1);

  localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
  localparam logic [HW-1:0] H_LAST     = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOT - 1);

  typedef enum logic [0:0] {
    WAIT_FIFO = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          active_s;
  logic          frame_start_s;
  logic          run_s;
  logic          rinc_s;

  // Counters, frame-start FSM, pop request and next registered outputs
  always_comb begin
    hcnt_d        = hcnt_q + HW'(1);
    vcnt_d        = vcnt_q;
    state_d       = state_q;
    active_s      = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
    frame_start_s = (hcnt_q == HW'(0)) && (vcnt_q == VW'(0)) && !rempty;

    if (hcnt_q == H_LAST) begin
      hcnt_d = HW'(0);
      if (vcnt_q == V_LAST) begin
        vcnt_d = VW'(0);
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else begin
      vcnt_d = vcnt_q;
    end

    case (state_q)
      WAIT_FIFO: begin
        if (frame_start_s) begin
          state_d = RUN;
        end else begin
          state_d = WAIT_FIFO;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = WAIT_FIFO;
    endcase

    // The frame-start cycle already streams pixel (0,0), so pops follow the next state.
    run_s   = (state_d == RUN);
    rinc_s  = NRST && run_s && active_s && !rempty;
    hs_d    = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
    vs_d    = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
    blank_d = active_s;
    rgb_d   = rinc_s ? rdata : 24'h000000;
  end

  // State, counters and registered VGA outputs with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= WAIT_FIFO;
      hcnt_q  <= HW'(0);
      vcnt_q  <= VW'(0);
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 24'h000000;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of streaming active pixels that found the FIFO empty
  always_comb begin
    ucnt_d = ucnt_q;
    if (run_s && active_s && rempty && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underflow counter register
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      ucnt_q <= 16'h0000;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`endif

  assign rinc              = rinc_s;
  assign vga_ifm.VGA_CLK   = ~CLK;
  assign vga_ifm.VGA_SYNC  = 1'b0;
  assign vga_ifm.VGA_HS    = hs_q;
  assign vga_ifm.VGA_VS    = vs_q;
  assign vga_ifm.VGA_BLANK = blank_q;
  assign vga_ifm.VGA_R     = rgb_q[23:16];
  assign vga_ifm.VGA_G     = rgb_q[15:8];
  assign vga_ifm.VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing at 160x90 (HTOT=288, VTOT=135) with a ramp FIFO.
module tb_vga_timing;
  localparam int HD     = 160;
  localparam int VD     = 90;
  localparam int HT     = 288;
  localparam int VT     = 135;
  localparam int HS_BEG = 200;
  localparam int HS_END = 248;
  localparam int VS_BEG = 103;
  localparam int VS_END = 106;

  logic        clk;
  logic        nrst;
  logic [23:0] rdata;
  logic        rempty;
  logic        rinc;
  logic [23:0] rgb_o;
`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  vga_if vga_bus ();

  vga_timing #(.HDISP(HD), .VDISP(VD)) dut (
    .CLK    (clk),
    .NRST   (nrst),
    .rdata  (rdata),
    .rempty (rempty),
    .rinc   (rinc),
`ifdef VGA_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .vga_ifm(vga_bus)
  );

  assign rgb_o = {vga_bus.VGA_R, vga_bus.VGA_G, vga_bus.VGA_B};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run;
  int          tests_failed;
  int          mh, mv;
  bit          m_run;
  logic        e_hs, e_vs, e_blank;
  logic [23:0] ramp;

  // Reference pop request for the current cycle, from the bench's own counters.
  function automatic logic model_rinc();
    return nrst && !rempty && (mh < HD) && (mv < VD) && (m_run || (mh == 0 && mv == 0));
  endfunction

  // One clock: advance the reference counters/outputs and act as the ramp FIFO.
  task automatic tick();
    logic c_pop, c_nrst, c_rempty;
    c_pop    = (rinc === 1'b1);
    c_nrst   = nrst;
    c_rempty = rempty;
    @(posedge clk);
    if (!c_nrst) begin
      mh = 0; mv = 0; m_run = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
    end else begin
      e_hs    = !(mh >= HS_BEG && mh < HS_END);
      e_vs    = !(mv >= VS_BEG && mv < VS_END);
      e_blank = (mh < HD) && (mv < VD);
      if (mh == 0 && mv == 0 && !c_rempty) m_run = 1'b1;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    #1;
    if (c_pop) ramp = ramp + 24'd1;
    rdata = ramp;
  endtask

  task automatic test_reset();
    int bad_rinc = 0;
    nrst = 1'b0; rempty = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      tick();
    end
    #1;
    tests_run++; if (bad_rinc !== 0) begin tests_failed++; $display("FAIL reset_rinc: %0d cycles with rinc=1, required 0", bad_rinc); end
    tests_run++; if (vga_bus.VGA_HS !== 1'b1) begin tests_failed++; $display("FAIL reset_hs: got %b, required 1", vga_bus.VGA_HS); end
    tests_run++; if (vga_bus.VGA_VS !== 1'b1) begin tests_failed++; $display("FAIL reset_vs: got %b, required 1", vga_bus.VGA_VS); end
    tests_run++; if (vga_bus.VGA_BLANK !== 1'b0) begin tests_failed++; $display("FAIL reset_blank: got %b, required 0", vga_bus.VGA_BLANK); end
    tests_run++; if (rgb_o !== 24'h000000) begin tests_failed++; $display("FAIL reset_rgb: got %h, required 000000", rgb_o); end
    tests_run++; if (vga_bus.VGA_SYNC !== 1'b0) begin tests_failed++; $display("FAIL reset_sync: got %b, required 0", vga_bus.VGA_SYNC); end
    tests_run++; if (vga_bus.VGA_CLK !== ~clk) begin tests_failed++; $display("FAIL vga_clk: got %b, required %b", vga_bus.VGA_CLK, ~clk); end
  endtask

  task automatic test_idle();
    int bad_rinc = 0, bad_rgb = 0, bad_blank = 0, bad_sync = 0, bad_lines = 0;
    int hs_low = 0, vs_low = 0;
    nrst = 1'b1; rempty = 1'b1;
    for (int i = 0; i < HT * VT; i++) begin
      if (i == 600) rempty = 1'b0;
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (rgb_o !== 24'h000000) bad_rgb++;
      if (vga_bus.VGA_BLANK !== e_blank) bad_blank++;
      if (vga_bus.VGA_HS !== e_hs || vga_bus.VGA_VS !== e_vs) bad_sync++;
      if (vga_bus.VGA_HS === 1'b0) hs_low++;
      if (vga_bus.VGA_VS === 1'b0) vs_low++;
      if (mh == HT - 1) begin
        if (hs_low != 48) bad_lines++;
        hs_low = 0;
      end
      tick();
    end
    tests_run++; if (bad_rinc !== 0) begin tests_failed++; $display("FAIL idle_rinc: %0d pops, required 0", bad_rinc); end
    tests_run++; if (bad_rgb !== 0) begin tests_failed++; $display("FAIL idle_rgb: %0d non-black cycles, required 0", bad_rgb); end
    tests_run++; if (bad_blank !== 0) begin tests_failed++; $display("FAIL idle_blank: %0d wrong cycles, required 0", bad_blank); end
    tests_run++; if (bad_sync !== 0) begin tests_failed++; $display("FAIL idle_sync_timing: %0d wrong cycles, required 0", bad_sync); end
    tests_run++; if (bad_lines !== 0) begin tests_failed++; $display("FAIL idle_hs_width: %0d lines without 48 low cycles, required 0", bad_lines); end
    tests_run++; if (vs_low !== 3 * HT) begin tests_failed++; $display("FAIL idle_vs_width: %0d low cycles, required %0d", vs_low, 3 * HT); end
  endtask

  task automatic test_stream();
    int first_h = -1, first_v = -1, line_pulses = 0, total = 0;
    int bad_lines = 0, bad_rgb = 0, bad_blank = 0, bad_model = 0;
    logic prev_rinc = 1'b0;
    logic [23:0] popped = 24'h000000;
    for (int i = 0; i < HT * VD; i++) begin
      #1;
      if (rinc === 1'b1) begin
        if (first_h < 0) begin first_h = mh; first_v = mv; end
        line_pulses++; total++;
      end
      if (prev_rinc) begin
        if (rgb_o !== popped) bad_rgb++;
      end else begin
        if (rgb_o !== 24'h000000) bad_rgb++;
      end
      if (vga_bus.VGA_BLANK !== prev_rinc) bad_blank++;
      if (rinc !== model_rinc() || vga_bus.VGA_HS !== e_hs || vga_bus.VGA_VS !== e_vs) bad_model++;
      if (mh == HT - 1) begin
        if (line_pulses != HD) bad_lines++;
        line_pulses = 0;
      end
      prev_rinc = (rinc === 1'b1);
      popped = rdata;
      tick();
    end
    tests_run++; if (first_h !== 0 || first_v !== 0) begin tests_failed++; $display("FAIL first_pop: at h=%0d v=%0d, required h=0 v=0", first_h, first_v); end
    tests_run++; if (total !== 14400) begin tests_failed++; $display("FAIL frame_pops: got %0d, required 14400", total); end
    tests_run++; if (bad_lines !== 0) begin tests_failed++; $display("FAIL line_pops: %0d lines without 160 pops, required 0", bad_lines); end
    tests_run++; if (bad_rgb !== 0) begin tests_failed++; $display("FAIL stream_rgb: %0d wrong pixels, required 0", bad_rgb); end
    tests_run++; if (bad_blank !== 0) begin tests_failed++; $display("FAIL stream_blank: %0d cycles not matching pops, required 0", bad_blank); end
    tests_run++; if (bad_model !== 0) begin tests_failed++; $display("FAIL stream_timing: %0d wrong cycles, required 0", bad_model); end
  endtask

  task automatic test_wrap();
    int bad_rinc = 0, bad_rgb = 0;
    for (int i = 0; i < HT * (VT - VD) - 1; i++) begin
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (rgb_o !== 24'h000000) bad_rgb++;
      tick();
    end
    #1;
    tests_run++; if (bad_rinc !== 0 || bad_rgb !== 0) begin tests_failed++; $display("FAIL porch_quiet: %0d pops %0d non-black, required 0 0", bad_rinc, bad_rgb); end
    tests_run++; if (rinc !== 1'b0 || vga_bus.VGA_BLANK !== 1'b0) begin tests_failed++; $display("FAIL wrap_last: rinc=%b blank=%b, required 0 0", rinc, vga_bus.VGA_BLANK); end
    tick();
    #1;
    tests_run++; if (rinc !== 1'b1 || vga_bus.VGA_BLANK !== 1'b0) begin tests_failed++; $display("FAIL wrap_first: rinc=%b blank=%b, required 1 0", rinc, vga_bus.VGA_BLANK); end
    tick();
    #1;
    tests_run++; if (vga_bus.VGA_BLANK !== 1'b1) begin tests_failed++; $display("FAIL wrap_blank_rise: got %b, required 1", vga_bus.VGA_BLANK); end
    tests_run++; if (rgb_o !== 24'd14400) begin tests_failed++; $display("FAIL wrap_pixel: got %0d, required 14400", rgb_o); end
  endtask

  task automatic test_underflow();
    int bad_rinc = 0, bad_rgb = 0;
    while (mh < 50) tick();
    for (int i = 0; i < 10; i++) begin
      rempty = 1'b1;
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (i > 0 && rgb_o !== 24'h000000) bad_rgb++;
      tick();
    end
    rempty = 1'b0;
    #1;
    if (rgb_o !== 24'h000000) bad_rgb++;
    tests_run++; if (bad_rinc !== 0) begin tests_failed++; $display("FAIL underflow_rinc: %0d pops, required 0", bad_rinc); end
    tests_run++; if (bad_rgb !== 0) begin tests_failed++; $display("FAIL underflow_rgb: %0d non-black, required 0", bad_rgb); end
    tests_run++; if (rinc !== 1'b1) begin tests_failed++; $display("FAIL underflow_resume: rinc=%b, required 1", rinc); end
    tick();
    #1;
    tests_run++; if (rgb_o !== 24'd14450) begin tests_failed++; $display("FAIL resume_pixel: got %0d, required 14450", rgb_o); end
`ifdef VGA_UNDERFLOW_CNT_EN
    tests_run++; if (underflow_cnt !== 16'd10) begin tests_failed++; $display("FAIL underflow_cnt: got %0d, required 10", underflow_cnt); end
`endif
  endtask

  task automatic test_mid_reset();
    int bad_rinc = 0, bad_rgb = 0, bad_blank = 0;
    while (!(mh == 100 && mv == 40)) tick();
    nrst = 1'b0;
    #1;
    tests_run++; if (rinc !== 1'b0) begin tests_failed++; $display("FAIL midreset_rinc: got %b, required 0", rinc); end
    tick();
    #1;
    tests_run++; if (vga_bus.VGA_HS !== 1'b1 || vga_bus.VGA_VS !== 1'b1) begin tests_failed++; $display("FAIL midreset_sync: hs=%b vs=%b, required 1 1", vga_bus.VGA_HS, vga_bus.VGA_VS); end
    tests_run++; if (vga_bus.VGA_BLANK !== 1'b0) begin tests_failed++; $display("FAIL midreset_blank: got %b, required 0", vga_bus.VGA_BLANK); end
    tests_run++; if (rgb_o !== 24'h000000) begin tests_failed++; $display("FAIL midreset_rgb: got %h, required 000000", rgb_o); end
    nrst = 1'b1; rempty = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 5) rempty = 1'b0;
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (rgb_o !== 24'h000000) bad_rgb++;
      if (vga_bus.VGA_BLANK !== e_blank) bad_blank++;
      tick();
    end
    tests_run++; if (bad_rinc !== 0) begin tests_failed++; $display("FAIL rewait_rinc: %0d pops, required 0", bad_rinc); end
    tests_run++; if (bad_rgb !== 0) begin tests_failed++; $display("FAIL rewait_rgb: %0d non-black, required 0", bad_rgb); end
    tests_run++; if (bad_blank !== 0) begin tests_failed++; $display("FAIL rewait_blank: %0d wrong cycles, required 0", bad_blank); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    nrst = 1'b0; rempty = 1'b1; rdata = 24'h000000; ramp = 24'h000000;
    mh = 0; mv = 0; m_run = 1'b0;
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
    test_reset();
    test_idle();
    test_stream();
    test_wrap();
    test_underflow();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
